systolic_array_4x4: RTL and testbench



---
 rtl/systolic_array_4x4_pkg.sv | 24 ++
 rtl/systolic_array_4x4_pe.sv | 40 ++++
 rtl/systolic_array_4x4.sv | 98 +++++++++
 tb/tb_systolic_array_4x4.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_4x4_pkg.sv
// Shared sizes and the ReLU/clamp helper for the 4x4 systolic array.
package systolic_array_4x4_pkg;

    localparam int DW      = 8;
    localparam int PSW     = 18;
    localparam int N       = 4;
    localparam int ACT_MAX = 127;

    typedef logic signed [DW-1:0]  data_t;
    typedef logic signed [PSW-1:0] psum_t;

    localparam psum_t ACT_MAX_PS = psum_t'(ACT_MAX);

    // ReLU with an upper clamp: negative -> 0, above ACT_MAX -> ACT_MAX.
    function automatic logic [DW-1:0] relu_clamp(input psum_t x);
        if (x < 0)
            return '0;
        else if (x > ACT_MAX_PS)
            return DW'(ACT_MAX);
        else
            return x[DW-1:0];
    endfunction

endpackage

// File: rtl/systolic_array_4x4_pe.sv
// One weight-stationary PE: latches its weight on w_en, passes the activation
// east and the accumulated partial sum south every cycle.
module systolic_pe
    import systolic_array_4x4_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  w_en,
    input  data_t w_in,
    input  data_t a_in,
    input  psum_t ps_in,
    output data_t a_out,
    output psum_t ps_out
);

    data_t                     w;
    logic signed [2*DW-1:0]    prod;

    assign prod = a_in * w;

    // Weight register, written only while this PE's row is selected.
    always_ff @(posedge clk) begin
        if (rst)
            w <= '0;
        else if (w_en)
            w <= w_in;
    end

    // Activation pass-through and multiply-accumulate run every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out  <= '0;
            ps_out <= '0;
        end else begin
            a_out  <= a_in;
            ps_out <= ps_in + {{(PSW-2*DW){prod[2*DW-1]}}, prod};
        end
    end

endmodule

// File: rtl/systolic_array_4x4.sv
// 4x4 weight-stationary int8 systolic matmul with ReLU/clamp on the bottom row.
module systolic_array_4x4
    import systolic_array_4x4_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start_signal,
    input  logic          wen,
    input  logic [DW-1:0] inp_north0,
    input  logic [DW-1:0] inp_north1,
    input  logic [DW-1:0] inp_north2,
    input  logic [DW-1:0] inp_north3,
    input  logic [DW-1:0] inp_west0,
    input  logic [DW-1:0] inp_west1,
    input  logic [DW-1:0] inp_west2,
    input  logic [DW-1:0] inp_west3,
    output logic [4:0]    count,
    output logic [DW-1:0] activation_result12,
    output logic [DW-1:0] activation_result13,
    output logic [DW-1:0] activation_result14,
    output logic [DW-1:0] activation_result15
);

    logic [N-1:0][DW-1:0] north;
    logic [N-1:0][DW-1:0] west;
    logic [N-1:0][DW-1:0] result;
    logic [1:0]           ptr;

    data_t a_grid  [N][N];
    psum_t ps_grid [N][N];

    assign north = {inp_north3, inp_north2, inp_north1, inp_north0};
    assign west  = {inp_west3, inp_west2, inp_west1, inp_west0};

    assign activation_result12 = result[0];
    assign activation_result13 = result[1];
    assign activation_result14 = result[2];
    assign activation_result15 = result[3];

    // Free-running schedule counter for the loader; wraps naturally at 31.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (start_signal)
            count <= count + 5'd1;
    end

    // Row pointer for weight loading; any gap in wen restarts at row 0.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (wen)
            ptr <= ptr + 2'd1;
        else
            ptr <= '0;
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            data_t a_in;
            psum_t ps_in;

            if (c == 0) begin : g_west
                assign a_in = data_t'(west[r]);
            end else begin : g_east
                assign a_in = a_grid[r][c-1];
            end

            if (r == 0) begin : g_top
                assign ps_in = '0;
            end else begin : g_below
                assign ps_in = ps_grid[r-1][c];
            end

            systolic_pe u_pe (
                .clk    (clk),
                .rst    (rst),
                .w_en   (wen && (ptr == 2'(r))),
                .w_in   (data_t'(north[c])),
                .a_in   (a_in),
                .ps_in  (ps_in),
                .a_out  (a_grid[r][c]),
                .ps_out (ps_grid[r][c])
            );
        end
    end

    // Output stage: registered activation of the bottom-row partial sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else begin
            for (int c = 0; c < N; c++)
                result[c] <= relu_clamp(ps_grid[N-1][c]);
        end
    end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Directed bench for systolic_array_4x4: reset, matmul cases, counter, reload.
module tb_systolic_array_4x4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_signal;
    logic       wen;
    logic [7:0] north [4];
    logic [7:0] west  [4];
    logic [4:0] count;
    logic [7:0] res   [4];

    int total = 0;
    int bad   = 0;

    // Stimulus/expectation matrices used by run_matmul: W[r][c], A[t][r], E[t][c].
    int wm [4][4];
    int am [4][4];
    int em [4][4];

    always #5 clk = ~clk;

    systolic_array_4x4 dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_signal        (start_signal),
        .wen                 (wen),
        .inp_north0          (north[0]),
        .inp_north1          (north[1]),
        .inp_north2          (north[2]),
        .inp_north3          (north[3]),
        .inp_west0           (west[0]),
        .inp_west1           (west[1]),
        .inp_west2           (west[2]),
        .inp_west3           (west[3]),
        .count               (count),
        .activation_result12 (res[0]),
        .activation_result13 (res[1]),
        .activation_result14 (res[2]),
        .activation_result15 (res[3])
    );

    task automatic clear_inputs();
        start_signal = 1'b0;
        wen          = 1'b0;
        for (int i = 0; i < 4; i++) begin
            north[i] = 8'd0;
            west[i]  = 8'd0;
        end
    endtask

    // Two reset cycles; returns at a negedge with rst released.
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives weights at counts 0..3 and skewed features, checking count and
    // every result in its valid window. Stops early at count == last.
    task automatic run_matmul(input string name, input int last);
        for (int cyc = 0; cyc <= last; cyc++) begin
            total++;
            if (count !== 5'(cyc)) begin
                bad++;
                $display("FAIL %s count: got %0d want %0d", name, count, cyc);
            end
            for (int c = 0; c < 4; c++) begin
                int t;
                t = cyc - 9 - c;
                if (t >= 0 && t < 4) begin
                    total++;
                    if (res[c] !== 8'(em[t][c])) begin
                        bad++;
                        $display("FAIL %s result%0d t=%0d: got %0d want %0d",
                                 name, 12 + c, t, res[c], em[t][c]);
                    end
                end
            end
            if (cyc == last) break;
            start_signal = 1'b1;
            wen          = (cyc < 4);
            for (int c = 0; c < 4; c++)
                north[c] = (cyc < 4) ? 8'(wm[cyc][c]) : 8'd0;
            for (int r = 0; r < 4; r++) begin
                int t;
                t = cyc - 4 - r;
                west[r] = (t >= 0 && t < 4) ? 8'(am[t][r]) : 8'd0;
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic load_identity();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                wm[i][j] = (i == j) ? 1 : 0;
                am[i][j] = 4 * i + j + 1;
                em[i][j] = 4 * i + j + 1;
            end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        start_signal = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (count !== 5'd0) begin
            bad++;
            $display("FAIL reset count: got %0d want 0", count);
        end
        for (int c = 0; c < 4; c++) begin
            total++;
            if (res[c] !== 8'd0) begin
                bad++;
                $display("FAIL reset result%0d: got %0d want 0", 12 + c, res[c]);
            end
        end
        rst = 1'b0;
        start_signal = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (count !== 5'd0) begin
            bad++;
            $display("FAIL reset_hold count: got %0d want 0", count);
        end
    endtask

    task automatic test_identity();
        do_reset();
        load_identity();
        run_matmul("identity", 18);
    endtask

    task automatic test_relu();
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                wm[i][j] = -1;
                am[i][j] = 5;
                em[i][j] = 0;  // -20 clipped
            end
        run_matmul("relu", 18);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                wm[i][j] = 100;
                am[i][j] = 100;
                em[i][j] = 127;  // 40000 clamped
            end
        run_matmul("saturate", 18);
        // W=1: each column sums the row vector.
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                wm[i][j] = 1;
        am[0] = '{-128, 127, 0, 0};      // -1  -> 0
        am[1] = '{1, 2, 3, 4};           // 10
        am[2] = '{-128, -128, 127, 127}; // -2  -> 0
        am[3] = '{50, 50, 50, 50};       // 200 -> 127
        for (int j = 0; j < 4; j++) begin
            em[0][j] = 0;
            em[1][j] = 10;
            em[2][j] = 0;
            em[3][j] = 127;
        end
        run_matmul("edge_sum", 18);
    endtask

    task automatic test_counter();
        do_reset();
        start_signal = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            total++;
            if (count !== 5'(i % 32)) begin
                bad++;
                $display("FAIL counter step %0d: got %0d want %0d", i, count, i % 32);
            end
        end
        start_signal = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (count !== 5'd1) begin
                bad++;
                $display("FAIL counter_hold: got %0d want 1", count);
            end
        end
    endtask

    task automatic test_midop_reset();
        do_reset();
        // Prime the array with a different weight set, abort at count 7.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                wm[i][j] = 3;
                am[i][j] = 7;
                em[i][j] = 0;
            end
        run_matmul("midop_pre", 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (count !== 5'd0) begin
            bad++;
            $display("FAIL midop count: got %0d want 0", count);
        end
        load_identity();
        run_matmul("midop_rerun", 18);
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Short burst of junk into rows 0,1, then a gap, then a full burst.
        wen = 1'b1;
        for (int i = 0; i < 4; i++) north[i] = 8'd9;
        repeat (2) @(negedge clk);
        clear_inputs();
        @(negedge clk);
        load_identity();
        run_matmul("reburst", 18);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_identity();
        test_relu();
        test_saturation();
        test_counter();
        test_midop_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
